// File: rtl/router_pkg.sv
// Shared types and helpers for the router 1x3 packet transmitter.
package router_pkg;

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_e;

    function automatic logic [BYTE_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: flop array with a clocked write port and a combinational read port.
module router_tx_buf
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [LEN_W-1:0]  wr_idx_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [LEN_W-1:0]  rd_idx_i,
    output logic [BYTE_W-1:0] rdata_c_o
);

    logic [BYTE_W-1:0] mem_q [MAX_LEN];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header, payload
// and parity bytes while honouring the router busy flag.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 63,
    parameter int unsigned IDLE_GAP = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic              corrupt_parity,
    input  logic [BYTE_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic [BYTE_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              tx_active,
    output logic              done,
    output logic              err
);

    localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              corrupt_q, corrupt_d;
    logic [LEN_W-1:0]  wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
    logic [BYTE_W-1:0] parity_q, parity_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              pl_ready_q, pl_ready_d;
    logic              tx_active_q, tx_active_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              buf_we_c;
    logic [LEN_W-1:0]  rd_addr_c;
    logic [BYTE_W-1:0] rd_data_c;
    logic              start_ok_c;
    logic              wr_last_c;
    logic              rd_last_c;

    router_tx_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clock     (clock),
        .we_i      (buf_we_c),
        .wr_idx_i  (wr_idx_q),
        .wdata_i   (pl_data),
        .rd_idx_i  (rd_addr_c),
        .rdata_c_o (rd_data_c)
    );

    assign start_ok_c = (payload_len != '0) && (32'(payload_len) <= MAX_LEN)
                        && (dest_addr != ADDR_INVALID);
    assign wr_last_c  = (wr_idx_q == len_q - LEN_W'(1));
    assign rd_last_c  = (rd_idx_q == len_q - LEN_W'(1));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        corrupt_d   = corrupt_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        parity_d    = parity_q;
        gap_d       = gap_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        pl_ready_d  = pl_ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        buf_we_c    = 1'b0;
        rd_addr_c   = '0;

        unique case (state_q)
            S_IDLE: begin
                pl_ready_d  = 1'b0;
                pkt_valid_d = 1'b0;
                if (start) begin
                    if (!start_ok_c) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = payload_len;
                        addr_d    = dest_addr;
                        corrupt_d = corrupt_parity;
                        parity_d  = pack_header(payload_len, dest_addr);
                        wr_idx_d  = '0;
                        rd_idx_d  = '0;
                        state_d   = S_FILL;
                    end
                end
            end
            S_FILL: begin
                pl_ready_d = 1'b1;
                if (pl_valid && pl_ready_q) begin
                    buf_we_c = 1'b1;
                    parity_d = parity_q ^ pl_data;
                    if (wr_last_c) begin
                        pl_ready_d  = 1'b0;
                        data_out_d  = pack_header(len_q, addr_q);
                        pkt_valid_d = 1'b1;
                        state_d     = S_HEADER;
                    end else begin
                        wr_idx_d = wr_idx_q + LEN_W'(1);
                    end
                end
            end
            S_HEADER: begin
                rd_addr_c = '0;
                if (!busy) begin
                    rd_idx_d   = '0;
                    data_out_d = rd_data_c;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // Look one byte ahead so the next byte is ready when this one is taken
                rd_addr_c = rd_last_c ? rd_idx_q : rd_idx_q + LEN_W'(1);
                if (!busy) begin
                    if (rd_last_c) begin
                        data_out_d  = parity_q ^ {{(BYTE_W-1){1'b0}}, corrupt_q};
                        pkt_valid_d = 1'b0;
                        state_d     = S_PARITY;
                    end else begin
                        rd_idx_d   = rd_idx_q + LEN_W'(1);
                        data_out_d = rd_data_c;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    data_out_d = '0;
                    gap_d      = '0;
                    done_d     = (GAP_LAST == '0);
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d  = gap_q + GAP_W'(1);
                    done_d = (gap_q + GAP_W'(1) == GAP_LAST);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tx_active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            corrupt_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            parity_q    <= '0;
            gap_q       <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            corrupt_q   <= corrupt_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            parity_q    <= parity_d;
            gap_q       <= gap_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            pl_ready_q  <= pl_ready_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign pkt_valid = pkt_valid_q;
    assign pl_ready  = pl_ready_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
